// File: rtl/phase_timer.sv
// Phase duration timer for the traffic-light sequencer: times the active one-hot
// phase and pulses g_end/y_end/r_end once. Optional hold port: PHASE_TIMER_HOLD_EN.
module phase_timer #(
  parameter int CLK_DIV = 50_000_000,
  parameter int G_TIME  = 30,
  parameter int Y_TIME  = 3,
  parameter int R_TIME  = 2,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fsm_g,
  input  logic          fsm_y,
  input  logic          fsm_r,
`ifdef PHASE_TIMER_HOLD_EN
  input  logic          hold,
`endif
  output logic          g_end,
  output logic          y_end,
  output logic          r_end,
  output logic [CW-1:0] remain,
  output logic          phase_err
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] G_LOAD    = CW'(G_TIME - 1);
  localparam logic [CW-1:0] Y_LOAD    = CW'(Y_TIME - 1);
  localparam logic [CW-1:0] R_LOAD    = CW'(R_TIME - 1);

  logic [2:0]    phase;
  logic          phase_valid;
  logic          new_phase;
  logic          hold_w;
  logic          running;
  logic          tick;
  logic [CW-1:0] load_val;

  logic [2:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic [2:0]    end_q, end_d;
  logic          err_q, err_d;

`ifdef PHASE_TIMER_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  assign phase       = {fsm_g, fsm_y, fsm_r};
  assign phase_valid = (phase == 3'b100) || (phase == 3'b010) || (phase == 3'b001);
  assign new_phase   = phase_valid && (phase != prev_q);
  // A load always wins over hold so the new phase starts frozen at DUR-1.
  assign running     = phase_valid && !new_phase && !done_q && !hold_w;
  assign tick        = running && (presc_q == PRESC_MAX);

  always_comb begin
    load_val = R_LOAD;
    if (phase[2]) begin
      load_val = G_LOAD;
    end else if (phase[1]) begin
      load_val = Y_LOAD;
    end
  end

  always_comb begin
    prev_d  = phase;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    done_d  = done_q;
    end_d   = 3'b000;
    err_d   = !phase_valid;
    if (new_phase) begin
      cnt_d   = load_val;
      presc_d = '0;
      done_d  = 1'b0;
    end else if (running) begin
      if (tick) begin
        presc_d = '0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Expiry: one pulse on the matching output, then stall until a new phase.
          done_d = 1'b1;
          end_d  = phase;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 3'b000;
      cnt_q   <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
      end_q   <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  assign g_end     = end_q[2];
  assign y_end     = end_q[1];
  assign r_end     = end_q[0];
  assign remain    = cnt_q;
  assign phase_err = err_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer (CLK_DIV=4, G=2, Y=3, R=2); hold scenario
// is compiled in only with PHASE_TIMER_HOLD_EN.
module tb_phase_timer;
  localparam int CLK_DIV = 4;
  localparam int G_TIME  = 2;
  localparam int Y_TIME  = 3;
  localparam int R_TIME  = 2;
  localparam int CW      = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fsm_g = 1'b0;
  logic          fsm_y = 1'b0;
  logic          fsm_r = 1'b0;
`ifdef PHASE_TIMER_HOLD_EN
  logic          hold = 1'b0;
`endif
  logic          g_end, y_end, r_end, phase_err;
  logic [CW-1:0] remain;

  int checks = 0;
  int passes = 0;

  phase_timer #(
    .CLK_DIV(CLK_DIV), .G_TIME(G_TIME), .Y_TIME(Y_TIME), .R_TIME(R_TIME), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .fsm_g(fsm_g), .fsm_y(fsm_y), .fsm_r(fsm_r),
`ifdef PHASE_TIMER_HOLD_EN
    .hold(hold),
`endif
    .g_end(g_end), .y_end(y_end), .r_end(r_end), .remain(remain), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_phase(input logic [2:0] p);
    {fsm_g, fsm_y, fsm_r} = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_phase(3'b000);
    step();
    step();
    checks++; if ({g_end, y_end, r_end} !== 3'b000) $display("FAIL reset_ends got %b want 000", {g_end, y_end, r_end}); else passes++;
    checks++; if (remain !== 8'd0) $display("FAIL reset_remain got %0d want 0", remain); else passes++;
    checks++; if (phase_err !== 1'b0) $display("FAIL reset_err got %b want 0", phase_err); else passes++;
  endtask

  task automatic test_first_phase();
    set_phase(3'b001);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      checks++; if (r_end !== (c == 9)) $display("FAIL first_r_end cycle %0d got %b want %b", c, r_end, (c == 9)); else passes++;
      checks++; if (remain !== ((c <= 4) ? 8'd1 : 8'd0)) $display("FAIL first_remain cycle %0d got %0d want %0d", c, remain, (c <= 4) ? 1 : 0); else passes++;
    end
    checks++; if (phase_err !== 1'b0) $display("FAIL first_err got %b want 0", phase_err); else passes++;
  endtask

  task automatic test_stall();
    int npulse;
    int first;
    npulse = 0;
    first  = -1;
    set_phase(3'b100);
    for (int c = 1; c <= 110; c++) begin
      step();
      if (g_end === 1'b1) begin
        npulse++;
        if (first < 0) first = c;
      end
    end
    checks++; if (npulse !== 1) $display("FAIL stall_pulses got %0d want 1", npulse); else passes++;
    checks++; if (first !== 9) $display("FAIL stall_latency got %0d want 9", first); else passes++;
    checks++; if (remain !== 8'd0) $display("FAIL stall_remain got %0d want 0", remain); else passes++;
  endtask

  task automatic test_phase_switch();
    set_phase(3'b010);
    step();
    checks++; if (remain !== 8'd2) $display("FAIL switch_yload got %0d want 2", remain); else passes++;
    step();
    checks++; if (remain !== 8'd2) $display("FAIL switch_yhold got %0d want 2", remain); else passes++;
    set_phase(3'b001);
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j == 1) begin
        checks++; if (remain !== 8'd1) $display("FAIL switch_rload got %0d want 1", remain); else passes++;
      end
      checks++; if (y_end !== 1'b0) $display("FAIL switch_y_end cycle %0d got %b want 0", j, y_end); else passes++;
      checks++; if (r_end !== (j == 9)) $display("FAIL switch_r_end cycle %0d got %b want %b", j, r_end, (j == 9)); else passes++;
    end
  endtask

  task automatic test_invalid();
    set_phase(3'b100);
    for (int c = 1; c <= 6; c++) step();
    checks++; if (remain !== 8'd0) $display("FAIL inv_pre_remain got %0d want 0", remain); else passes++;
    for (int k = 0; k < 6; k++) begin
      set_phase((k < 3) ? 3'b000 : 3'b110);
      step();
      checks++; if (phase_err !== 1'b1) $display("FAIL inv_err step %0d got %b want 1", k, phase_err); else passes++;
      checks++; if (remain !== 8'd0) $display("FAIL inv_remain step %0d got %0d want 0", k, remain); else passes++;
      checks++; if ({g_end, y_end, r_end} !== 3'b000) $display("FAIL inv_ends step %0d got %b want 000", k, {g_end, y_end, r_end}); else passes++;
    end
    set_phase(3'b100);
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 1) begin
        checks++; if (phase_err !== 1'b0) $display("FAIL inv_err_clear got %b want 0", phase_err); else passes++;
        checks++; if (remain !== 8'd1) $display("FAIL inv_reload got %0d want 1", remain); else passes++;
      end
      checks++; if (g_end !== (j == 9)) $display("FAIL inv_g_end cycle %0d got %b want %b", j, g_end, (j == 9)); else passes++;
    end
  endtask

  task automatic test_reset_midcount();
    set_phase(3'b001);
    for (int c = 1; c <= 8; c++) step();
    rst = 1'b1;
    step();
    checks++; if (r_end !== 1'b0) $display("FAIL rstmid_r_end got %b want 0", r_end); else passes++;
    checks++; if (remain !== 8'd0) $display("FAIL rstmid_remain got %0d want 0", remain); else passes++;
    rst = 1'b0;
    step();
    checks++; if (remain !== 8'd1) $display("FAIL rstmid_reload got %0d want 1", remain); else passes++;
  endtask

  task automatic test_full_loop();
    logic [2:0] exp_k [7] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
    int         exp_c [7] = '{9, 18, 31, 40, 49, 62, 71};
    logic [2:0] got_k [7];
    int         got_c [7];
    int         n;
    int         multi;
    logic [2:0] ends;
    n = 0;
    multi = 0;
    rst = 1'b1;
    set_phase(3'b001);
    step();
    step();
    rst = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      step();
      ends = {g_end, y_end, r_end};
      if (ends != 3'b000 && ends != 3'b100 && ends != 3'b010 && ends != 3'b001) multi++;
      if (ends != 3'b000 && n < 7) begin
        got_k[n] = ends;
        got_c[n] = c;
        n++;
      end
      if (r_end) set_phase(3'b100);
      else if (g_end) set_phase(3'b010);
      else if (y_end) set_phase(3'b001);
    end
    checks++; if (multi !== 0) $display("FAIL loop_multi got %0d want 0", multi); else passes++;
    checks++; if (n !== 7) $display("FAIL loop_count got %0d want 7", n); else passes++;
    for (int i = 0; i < n; i++) begin
      checks++; if (got_k[i] !== exp_k[i] || got_c[i] !== exp_c[i])
        $display("FAIL loop_event %0d got %b@%0d want %b@%0d", i, got_k[i], got_c[i], exp_k[i], exp_c[i]);
      else passes++;
    end
  endtask

`ifdef PHASE_TIMER_HOLD_EN
  task automatic test_hold();
    set_phase(3'b001);
    step();
    set_phase(3'b100);
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++; if (g_end !== (c == 14)) $display("FAIL hold_g_end cycle %0d got %b want %b", c, g_end, (c == 14)); else passes++;
      if (c == 8) begin
        checks++; if (remain !== 8'd1) $display("FAIL hold_remain got %0d want 1", remain); else passes++;
      end
      if (c == 3) hold = 1'b1;
      if (c == 8) hold = 1'b0;
    end
    set_phase(3'b010);
    step();
    step();
    hold = 1'b1;
    rst  = 1'b1;
    step();
    checks++; if ({g_end, y_end, r_end, phase_err} !== 4'b0000 || remain !== 8'd0)
      $display("FAIL hold_rst got ends %b err %b remain %0d want 000 0 0", {g_end, y_end, r_end}, phase_err, remain);
    else passes++;
    rst  = 1'b0;
    hold = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_phase();
    test_stall();
    test_phase_switch();
    test_invalid();
    test_reset_midcount();
    test_full_loop();
`ifdef PHASE_TIMER_HOLD_EN
    test_hold();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
